alu_seq: RTL and testbench

- Parametrised, registered successor to the processor's combinational ALU: WIDTH-bit datapath, internal flag register (S,Z,C,V), valid/ready handshake on both sides, multi-cycle shift-add multiply in the former don't-care opcode 7, sticky halt state.
- Sits between decode/register-read and writeback; downstream may stall.
- Branch conditions are evaluated against the internal flag register, so the external flag loop is removed.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_seq_shift.sv | 57 +++++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: instruction fields, flag bit
// positions and the control FSM states.
package alu_pkg;

  localparam logic [1:0] OP1_BR  = 2'b10;
  localparam logic [1:0] OP1_ALU = 2'b11;

  localparam logic [2:0] OP2_ADD    = 3'b100;
  localparam logic [2:0] OP2_BRANCH = 3'b111;

  localparam logic [3:0] OPC_ADD = 4'd0;
  localparam logic [3:0] OPC_SUB = 4'd1;
  localparam logic [3:0] OPC_AND = 4'd2;
  localparam logic [3:0] OPC_OR  = 4'd3;
  localparam logic [3:0] OPC_XOR = 4'd4;
  localparam logic [3:0] OPC_CMP = 4'd5;
  localparam logic [3:0] OPC_MOV = 4'd6;
  localparam logic [3:0] OPC_MUL = 4'd7;
  localparam logic [3:0] OPC_SLL = 4'd8;
  localparam logic [3:0] OPC_ROL = 4'd9;
  localparam logic [3:0] OPC_SRL = 4'd10;
  localparam logic [3:0] OPC_SRA = 4'd11;
  localparam logic [3:0] OPC_HLT = 4'd15;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;

  // Flag register layout is {S,Z,C,V}
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HALT
  } state_e;

  // Order matches opcode[1:0] of the shift group (8..11)
  typedef enum logic [1:0] {
    SH_SLL,
    SH_ROL,
    SH_SRL,
    SH_SRA
  } shift_e;

endpackage

// File: rtl/alu_seq_shift.sv
// Combinational barrel shifter/rotator with carry-out of the last bit shifted out.
module alu_seq_shift
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SH_W-1:0]  amt,
  input  shift_e           kind,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [SH_W:0] FULL = (SH_W+1)'(WIDTH);

  logic [WIDTH:0]        sll_ext;
  logic [WIDTH:0]        srl_ext;
  logic signed [WIDTH:0] sra_ext;
  logic [SH_W:0]         rol_back;
  logic [WIDTH-1:0]      rol_res;

  // One guard bit beyond the data catches the last bit shifted out
  assign sll_ext  = {1'b0, data} << amt;
  assign srl_ext  = {data, 1'b0} >> amt;
  assign sra_ext  = $signed({data, 1'b0}) >>> amt;
  assign rol_back = FULL - {1'b0, amt};
  assign rol_res  = (data << amt) | (data >> rol_back);

  always_comb begin
    result = sll_ext[WIDTH-1:0];
    carry  = sll_ext[WIDTH];
    case (kind)
      SH_SLL: begin
        result = sll_ext[WIDTH-1:0];
        carry  = sll_ext[WIDTH];
      end
      SH_ROL: begin
        result = rol_res;
        carry  = 1'b0;
      end
      SH_SRL: begin
        result = srl_ext[WIDTH:1];
        carry  = srl_ext[0];
      end
      SH_SRA: begin
        result = sra_ext[WIDTH:1];
        carry  = sra_ext[0];
      end
      default: begin
        result = sll_ext[WIDTH-1:0];
        carry  = sll_ext[WIDTH];
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with internal flag register, valid/ready handshakes,
// shift-add multiply and a sticky halt state.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op1,
  input  logic [2:0]       op2,
  input  logic [3:0]       opcode,
  input  logic [2:0]       cond,
  input  logic [SH_W-1:0]  d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             br_taken,
  output logic [3:0]       flags,
  output logic             halted
);

  localparam logic [SH_W:0] MUL_STEPS = (SH_W+1)'(WIDTH);

  state_e state, state_next;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [SH_W:0]      count;

  logic out_free, accept, is_mul, is_hlt, mul_done;
  logic add_v, sub_v, branch_true, shift_c;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] res;
  logic             res_br;
  logic [3:0]       res_flags;
  logic [3:0]       mul_flags;

  function automatic logic [3:0] sz_flags(input logic [WIDTH-1:0] v, input logic c);
    return {v[WIDTH-1], v == '0, c, 1'b0};
  endfunction

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op1 == OP1_ALU) && (opcode == OPC_MUL);
  assign is_hlt   = (op1 == OP1_ALU) && (opcode == OPC_HLT);
  assign mul_done = (state == ST_MUL) && (count == MUL_STEPS);
  assign halted   = (state == ST_HALT);

  assign add_ext = {1'b0, in1} + {1'b0, in2};
  assign sub_ext = {1'b0, in1} - {1'b0, in2};
  assign add_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_ext[WIDTH-1] != in1[WIDTH-1]);
  assign sub_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_ext[WIDTH-1] != in1[WIDTH-1]);

  assign mul_flags = {acc[WIDTH-1], acc[WIDTH-1:0] == '0,
                      |acc[2*WIDTH-1:WIDTH], |acc[2*WIDTH-1:WIDTH]};

  alu_seq_shift #(.WIDTH(WIDTH), .SH_W(SH_W)) u_shift (
    .data   (in2),
    .amt    (d),
    .kind   (shift_e'(opcode[1:0])),
    .result (shift_res),
    .carry  (shift_c)
  );

  // Branches test the registered flags, i.e. those of the previous accepted op
  always_comb begin
    branch_true = !flags[FLAG_Z];
    case (cond)
      COND_BE:  branch_true = flags[FLAG_Z];
      COND_BLT: branch_true = flags[FLAG_S] ^ flags[FLAG_V];
      COND_BLE: branch_true = flags[FLAG_Z] | (flags[FLAG_S] ^ flags[FLAG_V]);
      default:  branch_true = !flags[FLAG_Z];
    endcase
  end

  always_comb begin
    res       = add_ext[WIDTH-1:0];
    res_br    = 1'b0;
    res_flags = flags;
    case (op1)
      OP1_ALU: begin
        case (opcode)
          OPC_ADD: res_flags = {add_ext[WIDTH-1], add_ext[WIDTH-1:0] == '0, add_ext[WIDTH], add_v};
          OPC_SUB: begin
            res       = sub_ext[WIDTH-1:0];
            res_flags = {sub_ext[WIDTH-1], sub_ext[WIDTH-1:0] == '0, sub_ext[WIDTH], sub_v};
          end
          OPC_AND: begin
            res       = in1 & in2;
            res_flags = sz_flags(in1 & in2, 1'b0);
          end
          OPC_OR: begin
            res       = in1 | in2;
            res_flags = sz_flags(in1 | in2, 1'b0);
          end
          OPC_XOR: begin
            res       = in1 ^ in2;
            res_flags = sz_flags(in1 ^ in2, 1'b0);
          end
          OPC_CMP: begin
            res       = '0;
            res_flags = {sub_ext[WIDTH-1], sub_ext[WIDTH-1:0] == '0, sub_ext[WIDTH], sub_v};
          end
          OPC_MOV: begin
            res       = in2;
            res_flags = sz_flags(in2, 1'b0);
          end
          OPC_SLL, OPC_ROL, OPC_SRL, OPC_SRA: begin
            res       = shift_res;
            res_flags = sz_flags(shift_res, shift_c);
          end
          default: res = '0;
        endcase
      end
      OP1_BR: begin
        case (op2)
          OP2_ADD:    res = add_ext[WIDTH-1:0];
          OP2_BRANCH: begin
            res    = branch_true ? add_ext[WIDTH-1:0] : '0;
            res_br = branch_true;
          end
          default:    res = in2;
        endcase
      end
      default: res = add_ext[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul)      state_next = ST_MUL;
        else if (accept && is_hlt) state_next = ST_HALT;
      end
      ST_MUL:  if (mul_done && out_free) state_next = ST_IDLE;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // One multiplier bit per cycle; the finished product waits here until the output register frees
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, in1};
      mplier <= in2;
      acc    <= '0;
      count  <= '0;
    end else if (state == ST_MUL && count != MUL_STEPS) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      br_taken  <= 1'b0;
      flags     <= '0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      out       <= res;
      br_taken  <= res_br;
      flags     <= res_flags;
    end else if (mul_done && out_free) begin
      out_valid <= 1'b1;
      out       <= acc[WIDTH-1:0];
      br_taken  <= 1'b0;
      flags     <= mul_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against a cycle-level behavioural model.
module tb_alu_seq;

  localparam int     W    = 16;
  localparam int     SH   = $clog2(W);
  localparam longint MOD  = longint'(1) << W;
  localparam longint SMAX = (longint'(1) << (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W-1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in1 = '0, in2 = '0;
  logic [1:0]    op1 = '0;
  logic [2:0]    op2 = '0;
  logic [3:0]    opcode = '0;
  logic [2:0]    cond = '0;
  logic [SH-1:0] d = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out;
  logic          br_taken;
  logic [3:0]    flags;
  logic          halted;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op1       (op1),
    .op2       (op2),
    .opcode    (opcode),
    .cond      (cond),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .br_taken  (br_taken),
    .flags     (flags),
    .halted    (halted)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // Reference: what one accepted single-cycle op produces, from plain integer arithmetic
  function automatic void model_single(
    input logic [1:0] o1, input logic [2:0] o2, input logic [3:0] opc, input logic [2:0] cnd,
    input logic [W-1:0] a, input logic [W-1:0] b, input logic [SH-1:0] sh, input logic [3:0] fin,
    output logic [W-1:0] r, output logic br, output logic [3:0] fout);
    longint sa, sb, full, sres;
    logic   c, take;
    int     n;
    sa = a[W-1] ? longint'(a) - MOD : longint'(a);
    sb = b[W-1] ? longint'(b) - MOD : longint'(b);
    n  = int'(sh);
    full = longint'(a) + longint'(b);
    r = W'(full);
    br = 1'b0;
    fout = fin;
    if (o1 == 2'b11) begin
      case (opc)
        4'd0: begin
          r = W'(full);
          fout = {r[W-1], r == 0, full >= MOD, (sa + sb > SMAX) || (sa + sb < SMIN)};
        end
        4'd1, 4'd5: begin
          sres = sa - sb;
          r = W'(longint'(a) - longint'(b));
          fout = {r[W-1], r == 0, a < b, (sres > SMAX) || (sres < SMIN)};
          if (opc == 4'd5) r = '0;
        end
        4'd2: begin r = a & b; fout = {r[W-1], r == 0, 2'b00}; end
        4'd3: begin r = a | b; fout = {r[W-1], r == 0, 2'b00}; end
        4'd4: begin r = a ^ b; fout = {r[W-1], r == 0, 2'b00}; end
        4'd6: begin r = b; fout = {r[W-1], r == 0, 2'b00}; end
        4'd8: begin
          r = W'(longint'(b) << n);
          c = (n == 0) ? 1'b0 : 1'(longint'(b) >> (W - n));
          fout = {r[W-1], r == 0, c, 1'b0};
        end
        4'd9: begin
          r = W'((longint'(b) << n) | (longint'(b) >> (W - n)));
          fout = {r[W-1], r == 0, 2'b00};
        end
        4'd10: begin
          r = W'(longint'(b) >> n);
          c = (n == 0) ? 1'b0 : 1'(longint'(b) >> (n - 1));
          fout = {r[W-1], r == 0, c, 1'b0};
        end
        4'd11: begin
          r = W'(sb >>> n);
          c = (n == 0) ? 1'b0 : 1'(sb >>> (n - 1));
          fout = {r[W-1], r == 0, c, 1'b0};
        end
        default: r = '0;
      endcase
    end else if (o1 == 2'b10) begin
      if (o2 == 3'b111) begin
        case (cnd)
          3'b000:  take = fin[2];
          3'b001:  take = fin[3] ^ fin[0];
          3'b010:  take = fin[2] | (fin[3] ^ fin[0]);
          default: take = !fin[2];
        endcase
        r  = take ? W'(full) : '0;
        br = take;
      end else if (o2 != 3'b100) begin
        r = b;
      end
    end
  endfunction

  logic         m_out_valid, m_br, m_halt, m_busy, m_accepted;
  logic [W-1:0] m_out;
  logic [3:0]   m_flags;
  logic [2*W-1:0] m_prod;
  int           m_wait;

  always @(posedge clk or negedge rst_n) begin : model_step
    logic         free_now, acc_now, load;
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   f;
    if (!rst_n) begin
      m_out_valid = 1'b0; m_out = '0; m_br = 1'b0; m_flags = '0;
      m_halt = 1'b0; m_busy = 1'b0; m_wait = 0; m_prod = '0; m_accepted = 1'b0;
    end else begin
      free_now = !m_out_valid || out_ready;
      acc_now  = in_valid && !m_busy && !m_halt && free_now;
      m_accepted = acc_now;
      load = 1'b0;
      if (acc_now && op1 == 2'b11 && opcode == 4'd7) begin
        m_busy = 1'b1;
        m_wait = W;
        m_prod = (2*W)'(longint'(in1) * longint'(in2));
      end else if (acc_now) begin
        model_single(op1, op2, opcode, cond, in1, in2, d, m_flags, r, b, f);
        load = 1'b1; m_out = r; m_br = b; m_flags = f;
        if (op1 == 2'b11 && opcode == 4'd15) m_halt = 1'b1;
      end else if (m_busy && m_wait > 0) begin
        m_wait--;
      end else if (m_busy && free_now) begin
        load = 1'b1; m_busy = 1'b0;
        m_out = m_prod[W-1:0]; m_br = 1'b0;
        m_flags = {m_out[W-1], m_out == 0, m_prod[2*W-1:W] != 0, m_prod[2*W-1:W] != 0};
      end
      if (load) m_out_valid = 1'b1;
      else if (out_ready) m_out_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      checkOutput("out_valid", out_valid, m_out_valid);
      checkOutput("in_ready", in_ready, !m_busy && !m_halt && (!m_out_valid || out_ready));
      checkOutput("flags", flags, m_flags);
      checkOutput("halted", halted, m_halt);
      if (m_out_valid) begin
        checkOutput("out", out, m_out);
        checkOutput("br_taken", br_taken, m_br);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] o1, input logic [2:0] o2, input logic [3:0] opc,
                               input logic [2:0] cnd, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [SH-1:0] sh);
    bit done = 1'b0;
    in_valid = 1'b1; op1 = o1; op2 = o2; opcode = opc; cond = cnd; in1 = a; in2 = b; d = sh;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (m_accepted) done = 1'b1;
    end
    in_valid = 1'b0;
    checkOutput("accepted", done, 1);
  endtask

  task automatic expectResult(input string name, input logic [W-1:0] eo, input logic ebr, input logic [3:0] ef);
    checkOutput({name, " out_valid"}, out_valid, 1);
    checkOutput({name, " out"}, out, eo);
    checkOutput({name, " br_taken"}, br_taken, ebr);
    checkOutput({name, " flags"}, flags, ef);
    checkOutput({name, " model out"}, m_out, eo);
    checkOutput({name, " model flags"}, m_flags, ef);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int lat;
    bit got;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out", out, 0);
    checkOutput("reset flags", flags, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset in_ready", in_ready, 1);

    applyStimulus(2'b11, 3'b000, 4'd0, 3'b000, 16'h7FFF, 16'h0001, 4'd0);
    expectResult("add ovf", 16'h8000, 1'b0, 4'b1001);
    applyStimulus(2'b11, 3'b000, 4'd0, 3'b000, 16'hFFFF, 16'h0001, 4'd0);
    expectResult("add carry", 16'h0000, 1'b0, 4'b0110);
    applyStimulus(2'b11, 3'b000, 4'd5, 3'b000, 16'h0005, 16'h0005, 4'd0);
    expectResult("cmp", 16'h0000, 1'b0, 4'b0100);
    applyStimulus(2'b10, 3'b111, 4'd0, 3'b000, 16'h0010, 16'h0004, 4'd0);
    expectResult("be", 16'h0014, 1'b1, 4'b0100);
    applyStimulus(2'b10, 3'b111, 4'd0, 3'b011, 16'h0010, 16'h0004, 4'd0);
    expectResult("bne", 16'h0000, 1'b0, 4'b0100);

    applyStimulus(2'b11, 3'b000, 4'd7, 3'b000, 16'h0123, 16'h0010, 4'd0);
    checkOutput("mul in_ready", in_ready, 0);
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (out_valid) got = 1'b1;
      else checkOutput("mul busy in_ready", in_ready, 0);
    end
    checkOutput("mul latency", lat, 17);
    expectResult("mul", 16'h1230, 1'b0, 4'b0000);
    applyStimulus(2'b11, 3'b000, 4'd7, 3'b000, 16'h1000, 16'h0010, 4'd0);
    repeat (17) @(posedge clk);
    #1 expectResult("mul hi", 16'h0000, 1'b0, 4'b0111);

    applyStimulus(2'b11, 3'b000, 4'd11, 3'b000, 16'h0000, 16'h8001, 4'd1);
    expectResult("sra", 16'hC000, 1'b0, 4'b1010);
    applyStimulus(2'b11, 3'b000, 4'd10, 3'b000, 16'h0000, 16'h8001, 4'd4);
    expectResult("srl", 16'h0800, 1'b0, 4'b0000);
    applyStimulus(2'b11, 3'b000, 4'd9, 3'b000, 16'h0000, 16'h8001, 4'd4);
    expectResult("rol", 16'h0018, 1'b0, 4'b0000);
    applyStimulus(2'b11, 3'b000, 4'd8, 3'b000, 16'h0000, 16'h8001, 4'd0);
    expectResult("sll", 16'h8001, 1'b0, 4'b1000);

    @(posedge clk); #1;
    checkOutput("drained", out_valid, 0);
    out_ready = 1'b0;
    applyStimulus(2'b00, 3'b000, 4'd0, 3'b000, 16'h0001, 16'h0002, 4'd0);
    in_valid = 1'b1; in1 = 16'h0003; in2 = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stall in_ready", in_ready, 0);
      checkOutput("stall out", out, 16'h0003);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("release out", out, 16'h0007);
    @(posedge clk); #1;
    checkOutput("release drained", out_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 75);
      op1 = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       op2 = 3'b100;
        1, 2:    op2 = 3'b111;
        default: op2 = 3'($urandom);
      endcase
      opcode = 4'($urandom_range(0, 14));
      cond   = 3'($urandom);
      in1    = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      in2    = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      d      = SH'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    applyStimulus(2'b11, 3'b000, 4'd15, 3'b000, 16'h1234, 16'h5678, 4'd0);
    expectResult("hlt", 16'h0000, 1'b0, m_flags);
    checkOutput("hlt halted", halted, 1);
    in_valid = 1'b1; op1 = 2'b00; in1 = 16'h0001; in2 = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("halt in_ready", in_ready, 0);
      checkOutput("halt sticky", halted, 1);
    end
    checkOutput("halt drained", out_valid, 0);
    in_valid = 1'b0;

    rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    applyStimulus(2'b11, 3'b000, 4'd0, 3'b000, 16'h7FFF, 16'h0001, 4'd0);
    applyStimulus(2'b11, 3'b000, 4'd7, 3'b000, 16'h0003, 16'h0005, 4'd0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midmul reset out_valid", out_valid, 0);
    checkOutput("midmul reset out", out, 0);
    checkOutput("midmul reset flags", flags, 0);
    checkOutput("midmul reset br_taken", br_taken, 0);
    checkOutput("midmul reset halted", halted, 0);
    checkOutput("midmul reset in_ready", in_ready, 1);
    @(posedge clk); #3 rst_n = 1'b1;
    applyStimulus(2'b11, 3'b000, 4'd0, 3'b000, 16'h0002, 16'h0003, 4'd0);
    expectResult("post reset add", 16'h0005, 1'b0, 4'b0000);

    @(posedge clk); #1;
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
